// File: rtl/program_loader.sv
// Boot-time image loader: assembles little-endian words from a UART byte stream,
// writes them into instruction memory and releases the core once the checksum matches.
module program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   word_idx;
    logic [1:0]         byte_cnt;
    logic [7:0]         acc;
    logic [23:0]        word_buf;

    logic               fire;
    logic [LEN_W-1:0]   len_full;
    logic               last_word;

    assign fire      = rx_valid && rx_ready;
    assign len_full  = {rx_data, len[7:0]};
    assign last_word = (word_idx == len - LEN_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_LEN_LO: begin
                if (fire) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (fire) begin
                    if (len_full == '0)                    state_n = S_CHECK;
                    else if (32'(len_full) > MAX_WORDS)    state_n = S_ERROR;
                    else                                   state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (fire && (byte_cnt == 2'd3) && last_word) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (fire) state_n = (rx_data == acc) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (reload) state_n = S_LEN_LO;
            end
            default: state_n = S_LEN_LO;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            acc        <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            rx_ready   <= 1'b0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            rx_ready  <= (state_n != S_DONE) && (state_n != S_ERROR);
            done      <= (state_n == S_DONE);
            error     <= (state_n == S_ERROR);
            core_hold <= (state_n != S_DONE);

            case (state)
                S_LEN_LO: begin
                    if (fire) len[7:0] <= rx_data;
                end
                S_LEN_HI: begin
                    if (fire) begin
                        len[15:8] <= rx_data;
                        word_idx  <= '0;
                        byte_cnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        acc      <= acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx_data, word_buf};
                                imem_addr  <= BASE_ADDR + ADDR_W'({word_idx, 2'b00});
                                word_idx   <= word_idx + LEN_W'(1);
                            end
                        endcase
                    end
                end
                S_DONE, S_ERROR: begin
                    // imem_addr/imem_wdata keep the last write; memory is not cleared
                    if (reload) begin
                        len      <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        acc      <= '0;
                        word_buf <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
